ntt_load_sequencer: RTL and testbench

Sequences one NTT run from the 32-bit word stream produced by uart_reader. The first RADIX/2 words are twiddle factors. Each one is fanned out on the fly into the per-stage twiddle RAMs of top_top_module, with no twiddle buffer. The next RADIX words are data: they are buffered, then burst into the NTT behind a start pulse. The block then waits for done and re-arms for the next data set, or reloads twiddles when requested.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_tw_fanout.sv | 51 +++++
 rtl/ntt_load_sequencer.sv | 151 +++++++++++++++
 tb/tb_ntt_load_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT load sequencer.
// State encoding is exported on state_o for debug, so the values are fixed.
// stage_hit selects which twiddle RAMs take a given twiddle index.
package ntt_pkg;

   typedef enum logic [2:0] {
      TW_LOAD   = 3'd0,
      TW_WAIT   = 3'd1,
      DATA_LOAD = 3'd2,
      BURST     = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   localparam int RADIX_DEFAULT = 16;
   localparam int TW_WORDS      = RADIX_DEFAULT / 2;
   localparam int DATA_WORDS    = RADIX_DEFAULT;

   // True when twiddle index k belongs to stage s (k mod 2^s == 0).
   function automatic logic stage_hit(input logic [31:0] k, input int s);
      logic [31:0] mask;
      mask = (32'd1 << s) - 32'd1;
      return (k & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/ntt_tw_fanout.sv
// Purpose: fan one twiddle word out to every stage RAM whose stride divides its index.
// Latency: 1 cycle from valid to per-stage write enable/address/data.
// Backpressure: none; every valid produces its writes, enables last one cycle.
module ntt_tw_fanout
   import ntt_pkg::*;
#(
   parameter int W          = 32,
   parameter int NUM_STAGES = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             valid,
   input  logic [ADDR_WIDTH-1:0]            k,
   input  logic [W-1:0]                     word,
   output logic [NUM_STAGES-1:0]            wr_en,
   output logic [NUM_STAGES*ADDR_WIDTH-1:0] wr_addr,
   output logic [NUM_STAGES*W-1:0]          wr_data
);

   logic [31:0]           k_ext;
   logic [NUM_STAGES-1:0] hit;

   assign k_ext = 32'(k);

   // Which stages take this index: stage s keeps every 2^s-th twiddle.
   always_comb begin
      hit = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         hit[s] = stage_hit(k_ext, s);
      end
   end

   // Register the writes; address and data hold between writes, enable pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            wr_en[s] <= valid && hit[s];
            if (valid && hit[s]) begin
               wr_addr[s*ADDR_WIDTH +: ADDR_WIDTH] <= k >> s;
               wr_data[s*W +: W]                   <= word;
            end
         end
      end
   end

endmodule

// File: rtl/ntt_load_sequencer.sv
// Purpose: route the word stream into twiddle RAMs, buffer a data set, burst it into the NTT.
// Latency: twiddle writes 1 cycle after the word; burst starts the cycle after the last data word.
// Backpressure: none available upstream; words arriving while not accepting are dropped, overflow_o sticks.
module ntt_load_sequencer
   import ntt_pkg::*;
#(
   parameter int W          = 32,
   parameter int RADIX      = DATA_WORDS,
   parameter int NUM_STAGES = $clog2(RADIX),
   parameter int ADDR_WIDTH = $clog2(RADIX/2)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             word_valid_i,
   input  logic [W-1:0]                     word_data_i,
   input  logic                             reload_tw_i,
   output logic [NUM_STAGES-1:0]            wr_en_o,
   output logic [NUM_STAGES*ADDR_WIDTH-1:0] wr_addr_o,
   output logic [NUM_STAGES*W-1:0]          wr_data_o,
   input  logic [NUM_STAGES-1:0]            full_ram_i,
   output logic                             start_o,
   output logic [W-1:0]                     ntt_data_o,
   input  logic                             ntt_done_i,
   output logic                             busy_o,
   output logic                             overflow_o,
   output logic [2:0]                       state_o
);

   localparam int TW_N = RADIX / 2;
   localparam int TCW  = $clog2(TW_N + 1);
   localparam int DCW  = $clog2(RADIX + 1);
   localparam int BAW  = $clog2(RADIX);

   localparam logic [TCW-1:0] TW_LAST   = TCW'(TW_N - 1);
   localparam logic [DCW-1:0] DATA_LAST = DCW'(RADIX - 1);
   localparam logic [DCW-1:0] BURST_END = DCW'(RADIX);

   state_t         state;
   state_t         state_nxt;
   logic [TCW-1:0] tw_cnt;     // twiddles received in this load
   logic [DCW-1:0] idx;        // data words buffered in this set
   logic [DCW-1:0] burst_j;    // index of the next buffer word to present
   logic [W-1:0]   data_buf [RADIX];

   logic tw_vld;
   logic data_vld;
   logic drop_vld;
   logic data_last;
   logic run_done;

   assign tw_vld    = word_valid_i && (state == TW_LOAD);
   assign data_vld  = word_valid_i && (state == DATA_LOAD);
   assign drop_vld  = word_valid_i && ((state == TW_WAIT) || (state == BURST) ||
                                       (state == WAIT_DONE));
   assign data_last = data_vld && (idx == DATA_LAST);
   assign run_done  = (state == WAIT_DONE) && ntt_done_i;
   assign state_o   = state;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= TW_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and busy decode; a word on a transition cycle obeys the old state.
   always_comb begin
      state_nxt = state;
      busy_o    = 1'b1;
      case (state)
         TW_LOAD: begin
            if (tw_cnt == '0) busy_o = 1'b0;
            if (tw_vld && (tw_cnt == TW_LAST)) state_nxt = TW_WAIT;
         end
         TW_WAIT: begin
            if (&full_ram_i) state_nxt = DATA_LOAD;
         end
         DATA_LOAD: begin
            if (idx == '0) busy_o = 1'b0;
            if (data_last) state_nxt = BURST;
         end
         BURST: begin
            if (burst_j == BURST_END) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (ntt_done_i) state_nxt = reload_tw_i ? TW_LOAD : DATA_LOAD;
         end
         default: state_nxt = TW_LOAD;
      endcase
   end

   // Counters and burst output; word 0 is launched on the edge that stores the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tw_cnt     <= '0;
         idx        <= '0;
         burst_j    <= '0;
         start_o    <= 1'b0;
         ntt_data_o <= '0;
      end else begin
         start_o <= 1'b0;
         if (tw_vld) tw_cnt <= tw_cnt + TCW'(1);
         if (data_vld) idx <= idx + DCW'(1);
         if (data_last) begin
            start_o    <= 1'b1;
            ntt_data_o <= data_buf[0];
            burst_j    <= DCW'(1);
         end else if ((state == BURST) && (burst_j != BURST_END)) begin
            ntt_data_o <= data_buf[burst_j[BAW-1:0]];
            burst_j    <= burst_j + DCW'(1);
         end
         if (run_done) begin
            tw_cnt  <= '0;
            idx     <= '0;
            burst_j <= '0;
         end
      end
   end

   // Data buffer; contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) begin
      if (data_vld) data_buf[idx[BAW-1:0]] <= word_data_i;
   end

   // Sticky flag for words that arrived while nothing could accept them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_o <= 1'b0;
      end else if (drop_vld) begin
         overflow_o <= 1'b1;
      end
   end

   ntt_tw_fanout #(
      .W          (W),
      .NUM_STAGES (NUM_STAGES),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fanout (
      .clk     (clk),
      .rst     (rst),
      .valid   (tw_vld),
      .k       (tw_cnt[ADDR_WIDTH-1:0]),
      .word    (word_data_i),
      .wr_en   (wr_en_o),
      .wr_addr (wr_addr_o),
      .wr_data (wr_data_o)
   );

endmodule

// File: tb/tb_ntt_load_sequencer.sv
// Bench for ntt_load_sequencer at RADIX=16.
// Scoreboard queues for twiddle writes and burst words, plus directed checks.
// Stimulus changes 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_ntt_load_sequencer;

   localparam int W     = 32;
   localparam int RADIX = 16;
   localparam int NS    = 4;
   localparam int AW    = 3;

   localparam logic [2:0] S_TW_LOAD = 3'd0;
   localparam logic [2:0] S_TW_WAIT = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_BURST   = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              word_valid_i = 1'b0;
   logic [W-1:0]      word_data_i = '0;
   logic              reload_tw_i = 1'b0;
   logic [NS-1:0]     wr_en_o;
   logic [NS*AW-1:0]  wr_addr_o;
   logic [NS*W-1:0]   wr_data_o;
   logic [NS-1:0]     full_ram_i = '0;
   logic              start_o;
   logic [W-1:0]      ntt_data_o;
   logic              ntt_done_i = 1'b0;
   logic              busy_o;
   logic              overflow_o;
   logic [2:0]        state_o;

   ntt_load_sequencer #(.W(W), .RADIX(RADIX)) dut (
      .clk          (clk),
      .rst          (rst),
      .word_valid_i (word_valid_i),
      .word_data_i  (word_data_i),
      .reload_tw_i  (reload_tw_i),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .full_ram_i   (full_ram_i),
      .start_o      (start_o),
      .ntt_data_o   (ntt_data_o),
      .ntt_done_i   (ntt_done_i),
      .busy_o       (busy_o),
      .overflow_o   (overflow_o),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   typedef struct { int stage; logic [AW-1:0] addr; logic [W-1:0] data; } wr_exp_t;
   typedef struct { logic start; logic [W-1:0] data; } burst_exp_t;
   typedef struct { logic [W-1:0] word; logic [NS-1:0] exp_en; } tw_vec_t;

   wr_exp_t    exp_wr[$];
   burst_exp_t exp_burst[$];
   wr_exp_t    mon_wr;
   burst_exp_t mon_b;
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word is presented for exactly one rising edge; caller sits 1 unit after an edge.
   task automatic send_word(input logic [W-1:0] w);
      word_valid_i = 1'b1;
      word_data_i  = w;
      @(posedge clk);
      #1;
      word_valid_i = 1'b0;
   endtask

   task automatic push_tw(input int k, input logic [W-1:0] w);
      for (int s = 0; s < NS; s++) begin
         if (k % (1 << s) == 0) exp_wr.push_back('{s, AW'(k >> s), w});
      end
   endtask

   task automatic send_tw(input logic [W-1:0] base);
      for (int k = 0; k < RADIX/2; k++) begin
         push_tw(k, base + W'(k));
         send_word(base + W'(k));
      end
   endtask

   task automatic push_burst(input logic [W-1:0] base);
      for (int j = 0; j < RADIX; j++) exp_burst.push_back('{(j == 0), base + W'(j)});
   endtask

   task automatic send_data(input logic [W-1:0] base);
      push_burst(base);
      for (int j = 0; j < RADIX; j++) send_word(base + W'(j));
   endtask

   task automatic wait_state(input logic [2:0] s, input string name);
      int n = 0;
      while (state_o !== s && n < 200) begin
         tick();
         n++;
      end
      check(name, 64'(state_o), 64'(s));
   endtask

   // Scoreboard monitors: every enabled stage write and every burst cycle pops one entry.
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NS; s++) begin
            if (wr_en_o[s]) begin
               if (exp_wr.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL wr_unexpected: stage %0d addr %0h data %0h, none expected",
                           s, wr_addr_o[s*AW +: AW], wr_data_o[s*W +: W]);
               end else begin
                  mon_wr = exp_wr.pop_front();
                  check("wr_stage", 64'(s), 64'(mon_wr.stage));
                  check("wr_addr", 64'(wr_addr_o[s*AW +: AW]), 64'(mon_wr.addr));
                  check("wr_data", 64'(wr_data_o[s*W +: W]), 64'(mon_wr.data));
               end
            end
         end
         if (state_o == S_BURST) begin
            if (exp_burst.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL burst_extra: data %0h start %0b, none expected", ntt_data_o, start_o);
            end else begin
               mon_b = exp_burst.pop_front();
               check("burst_start", 64'(start_o), 64'(mon_b.start));
               check("burst_data", 64'(ntt_data_o), 64'(mon_b.data));
            end
         end else if (start_o) begin
            n_vec++;
            n_err++;
            $display("FAIL start_outside_burst: state %0d, start_o=1, required 0", state_o);
         end
      end
   end

   initial begin
      tw_vec_t tv[8];
      tv[0] = '{32'd100, 4'b1111};
      tv[1] = '{32'd101, 4'b0001};
      tv[2] = '{32'd102, 4'b0011};
      tv[3] = '{32'd103, 4'b0001};
      tv[4] = '{32'd104, 4'b0111};
      tv[5] = '{32'd105, 4'b0001};
      tv[6] = '{32'd106, 4'b0011};
      tv[7] = '{32'd107, 4'b0001};

      // Reset state
      tick();
      tick();
      check("rst_state", 64'(state_o), 64'(S_TW_LOAD));
      check("rst_wr_en", 64'(wr_en_o), 64'd0);
      check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
      check("rst_wr_data_lo", wr_data_o[63:0], 64'd0);
      check("rst_wr_data_hi", wr_data_o[127:64], 64'd0);
      check("rst_start", 64'(start_o), 64'd0);
      check("rst_ntt_data", 64'(ntt_data_o), 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      rst = 1'b0;
      tick();

      // Twiddles 100..107 from the table; each enable pattern lasts one cycle
      for (int i = 0; i < 8; i++) begin
         push_tw(i, tv[i].word);
         send_word(tv[i].word);
         check($sformatf("tw%0d_en", i), 64'(wr_en_o), 64'(tv[i].exp_en));
         if (i == 0) begin
            check("tw0_busy", 64'(busy_o), 64'd1);
            check("tw0_addr_all", 64'(wr_addr_o), 64'd0);
            check("tw0_data_s3", 64'(wr_data_o[3*W +: W]), 64'd100);
         end
         tick();
         check($sformatf("tw%0d_en_drop", i), 64'(wr_en_o), 64'd0);
      end
      check("tw_done_state", 64'(state_o), 64'(S_TW_WAIT));

      // Partial full_ram: stays in TW_WAIT, words dropped
      full_ram_i = 4'b0111;
      for (int i = 0; i < 5; i++) begin
         if (i == 1 || i == 3) send_word(W'(900 + i));
         else tick();
         check("tw_wait_hold", 64'(state_o), 64'(S_TW_WAIT));
      end
      check("ovf_tw_wait", 64'(overflow_o), 64'd1);
      full_ram_i = 4'b1111;
      tick();
      check("data_load_entry", 64'(state_o), 64'(S_DATA));
      check("data_load_idle", 64'(busy_o), 64'd0);

      // Data 1..16 -> burst
      push_burst(W'(1));
      for (int j = 0; j < RADIX; j++) begin
         send_word(W'(j + 1));
         if (j == 0) check("data_busy", 64'(busy_o), 64'd1);
      end
      check("b1_state", 64'(state_o), 64'(S_BURST));
      check("b1_start", 64'(start_o), 64'd1);
      check("b1_first", 64'(ntt_data_o), 64'd1);
      wait_state(S_WAIT, "b1_end");
      check("b1_drained", 64'(exp_burst.size()), 64'd0);
      check("hold_after_burst", 64'(ntt_data_o), 64'd16);

      // Re-arm without twiddles; done outside WAIT_DONE is ignored
      reload_tw_i = 1'b0;
      ntt_done_i  = 1'b1;
      tick();
      ntt_done_i  = 1'b0;
      check("rearm_data", 64'(state_o), 64'(S_DATA));
      push_burst(W'(17));
      for (int j = 0; j < RADIX; j++) begin
         if (j == 4) ntt_done_i = 1'b1;
         send_word(W'(17 + j));
         ntt_done_i = 1'b0;
         if (j == 4) check("done_ignored", 64'(state_o), 64'(S_DATA));
      end
      check("b2_start", 64'(start_o), 64'd1);
      wait_state(S_WAIT, "b2_end");
      check("b2_drained", 64'(exp_burst.size()), 64'd0);

      // Reload twiddles 200..207 back-to-back
      reload_tw_i = 1'b1;
      ntt_done_i  = 1'b1;
      tick();
      ntt_done_i  = 1'b0;
      reload_tw_i = 1'b0;
      check("reload_state", 64'(state_o), 64'(S_TW_LOAD));
      send_tw(W'(200));
      check("tw2_state", 64'(state_o), 64'(S_TW_WAIT));
      tick();
      check("tw2_data", 64'(state_o), 64'(S_DATA));
      check("tw2_drained", 64'(exp_wr.size()), 64'd0);

      // Reset in the middle of a burst
      send_data(W'(33));
      check("b3_state", 64'(state_o), 64'(S_BURST));
      tick();
      tick();
      tick();
      rst = 1'b1;
      exp_burst.delete();
      #1;
      check("midrst_state", 64'(state_o), 64'(S_TW_LOAD));
      check("midrst_ovf", 64'(overflow_o), 64'd0);
      tick();
      check("midrst_state_next", 64'(state_o), 64'(S_TW_LOAD));
      check("midrst_start", 64'(start_o), 64'd0);
      rst = 1'b0;
      tick();

      // Twiddle reload after reset, then a clean run
      send_tw(W'(300));
      check("tw3_state", 64'(state_o), 64'(S_TW_WAIT));
      tick();
      check("tw3_data", 64'(state_o), 64'(S_DATA));
      check("tw3_drained", 64'(exp_wr.size()), 64'd0);
      send_data(W'(1000));
      wait_state(S_WAIT, "b4_end");
      check("b4_no_ovf", 64'(overflow_o), 64'd0);

      // Extra word in WAIT_DONE is dropped; next burst is exactly the next 16 words
      send_word(W'(5555));
      check("ovf_wait_done", 64'(overflow_o), 64'd1);
      check("extra_state", 64'(state_o), 64'(S_WAIT));
      ntt_done_i = 1'b1;
      tick();
      ntt_done_i = 1'b0;
      check("rearm2_data", 64'(state_o), 64'(S_DATA));
      send_data(W'(2000));
      check("b5_start", 64'(start_o), 64'd1);
      check("b5_first", 64'(ntt_data_o), 64'd2000);
      wait_state(S_WAIT, "b5_end");
      check("b5_drained", 64'(exp_burst.size()), 64'd0);
      check("wr_all_seen", 64'(exp_wr.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
